lsu_wb: RTL and testbench

- Memory-access/writeback stage that sits directly upstream of the general-purpose register file.
- Accepts one instruction at a time from execute and issues load/store requests to the data-memory port.
- Aligns and sign/zero-extends load data, then drives the register file write port (rd_we/rd_waddr/rd_wdata) as a registered one-cycle pulse.
- Non-memory instructions pass the ALU result through to writeback.

---
 rtl/lsu_wb_pkg.sv | 46 ++++
 rtl/lsu_wb_load_align.sv | 33 +++
 rtl/lsu_wb.sv | 197 +++++++++++++++++++
 tb/tb_lsu_wb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_wb_pkg.sv
`default_nettype none
// ============================================================================
// lsu_wb_pkg : memory-op encodings, FSM state codes and decode helpers
// Revision   : 1.0
// ============================================================================
package lsu_wb_pkg;

    localparam int MEM_OP_W = 4;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LH   = 4'd2,
        MEM_OP_LW   = 4'd3,
        MEM_OP_LBU  = 4'd4,
        MEM_OP_LHU  = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } lsu_state_e;

    // Unassigned encodings collapse onto NONE so they behave as ALU ops.
    function automatic mem_op_e decode_op(input logic [MEM_OP_W-1:0] raw);
        return (raw > 4'd8) ? MEM_OP_NONE : mem_op_e'(raw);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return off[0];
            MEM_OP_LW, MEM_OP_SW:             return off != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_wb_load_align.sv
`default_nettype none
// ============================================================================
// lsu_wb_load_align : load lane select plus sign/zero extension
// Revision          : 1.0
// ============================================================================
module lsu_wb_load_align
    import lsu_wb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    addr_lo,
    input  mem_op_e       op,
    output logic [DW-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            MEM_OP_LB:  data = {{(DW-8){byte_sel[7]}}, byte_sel};
            MEM_OP_LBU: data = {{(DW-8){1'b0}}, byte_sel};
            MEM_OP_LH:  data = {{(DW-16){half_sel[15]}}, half_sel};
            MEM_OP_LHU: data = {{(DW-16){1'b0}}, half_sel};
            default:    data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_wb.sv
`default_nettype none
// ============================================================================
// lsu_wb   : memory-access / writeback stage feeding the register file
// Revision : 1.0
// ============================================================================
module lsu_wb
    import lsu_wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [3:0]    ex_mem_op,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_store_data,
    input  logic          ex_rd_we,
    input  logic [4:0]    ex_rd_waddr,
    input  logic [DW-1:0] ex_alu_result,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_we,
    output logic [AW-1:0] mem_req_addr,
    output logic [DW-1:0] mem_req_wdata,
    output logic [3:0]    mem_req_wstrb,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_rdata,
    output logic          wb_rd_we,
    output logic [4:0]    wb_rd_waddr,
    output logic [DW-1:0] wb_rd_wdata,
    output logic          misalign
);

    lsu_state_e    state_q, state_d;
    mem_op_e       op_q, op_d, ex_op;
    logic [1:0]    off_q, off_d;
    logic          rd_we_q, rd_we_d;
    logic [4:0]    rd_waddr_q, rd_waddr_d;
    logic          ex_ready_q, ex_ready_d;
    logic          req_valid_q, req_valid_d;
    logic          req_we_q, req_we_d;
    logic [AW-1:0] req_addr_q, req_addr_d;
    logic [DW-1:0] req_wdata_q, req_wdata_d;
    logic [3:0]    req_wstrb_q, req_wstrb_d;
    logic          wb_we_q, wb_we_d;
    logic [4:0]    wb_waddr_q, wb_waddr_d;
    logic [DW-1:0] wb_wdata_q, wb_wdata_d;
    logic          misalign_q, misalign_d;
    logic [DW-1:0] load_data;

    lsu_wb_load_align #(.DW(DW)) u_load_align (
        .rdata   (mem_rsp_rdata),
        .addr_lo (off_q),
        .op      (op_q),
        .data    (load_data)
    );

    always_comb begin
        ex_op       = decode_op(ex_mem_op);
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        rd_we_d     = rd_we_q;
        rd_waddr_d  = rd_waddr_q;
        ex_ready_d  = ex_ready_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        wb_we_d     = 1'b0;
        wb_waddr_d  = wb_waddr_q;
        wb_wdata_d  = wb_wdata_q;
        misalign_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    op_d       = ex_op;
                    off_d      = ex_addr[1:0];
                    rd_we_d    = ex_rd_we;
                    rd_waddr_d = ex_rd_waddr;
                    if (ex_op == MEM_OP_NONE) begin
                        if (ex_rd_we && (ex_rd_waddr != 5'd0)) begin
                            wb_we_d    = 1'b1;
                            wb_waddr_d = ex_rd_waddr;
                            wb_wdata_d = ex_alu_result;
                        end
                    end else if (is_misaligned(ex_op, ex_addr[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        ex_ready_d  = 1'b0;
                        req_valid_d = 1'b1;
                        req_we_d    = is_store(ex_op);
                        req_addr_d  = {ex_addr[AW-1:2], 2'b00};
                        case (ex_op)
                            MEM_OP_SB: begin
                                req_wdata_d = {4{ex_store_data[7:0]}};
                                req_wstrb_d = 4'b0001 << ex_addr[1:0];
                            end
                            MEM_OP_SH: begin
                                req_wdata_d = {2{ex_store_data[15:0]}};
                                req_wstrb_d = 4'b0011 << ex_addr[1:0];
                            end
                            MEM_OP_SW: begin
                                req_wdata_d = ex_store_data;
                                req_wstrb_d = 4'hF;
                            end
                            default: begin
                                req_wdata_d = '0;
                                req_wstrb_d = 4'h0;
                            end
                        endcase
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (req_we_q) begin
                        state_d    = ST_IDLE;
                        ex_ready_d = 1'b1;
                    end else begin
                        state_d = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (mem_rsp_valid) begin
                    state_d    = ST_IDLE;
                    ex_ready_d = 1'b1;
                    if (rd_we_q && (rd_waddr_q != 5'd0)) begin
                        wb_we_d    = 1'b1;
                        wb_waddr_d = rd_waddr_q;
                        wb_wdata_d = load_data;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ex_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= MEM_OP_NONE;
            off_q       <= 2'b00;
            rd_we_q     <= 1'b0;
            rd_waddr_q  <= 5'd0;
            ex_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= 4'h0;
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= 5'd0;
            wb_wdata_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rd_we_q     <= rd_we_d;
            rd_waddr_q  <= rd_waddr_d;
            ex_ready_q  <= ex_ready_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            wb_we_q     <= wb_we_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
            misalign_q  <= misalign_d;
        end
    end

    assign ex_ready      = ex_ready_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wstrb = req_wstrb_q;
    assign wb_rd_we      = wb_we_q;
    assign wb_rd_waddr   = wb_waddr_q;
    assign wb_rd_wdata   = wb_wdata_q;
    assign misalign      = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_wb.sv
`default_nettype none
// ============================================================================
// tb_lsu_wb : scoreboard bench for lsu_wb with a behavioural memory model
// Revision  : 1.0
// ============================================================================
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_rd_we;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_addr, ex_store_data, ex_alu_result;
    logic [4:0]  ex_rd_waddr;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        wb_rd_we;
    logic [4:0]  wb_rd_waddr;
    logic [31:0] wb_rd_wdata;
    logic        misalign;

    always #5 clk = ~clk;

    lsu_wb #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_mem_op     (ex_mem_op),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .ex_rd_we      (ex_rd_we),
        .ex_rd_waddr   (ex_rd_waddr),
        .ex_alu_result (ex_alu_result),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .wb_rd_we      (wb_rd_we),
        .wb_rd_waddr   (wb_rd_waddr),
        .wb_rd_wdata   (wb_rd_wdata),
        .misalign      (misalign)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_t;

    req_t        exp_req[$];
    wb_t         exp_wb[$];
    int          exp_mis = 0;
    int          checks = 0;
    int          errors = 0;
    bit          rsp_pending = 0;
    bit          hold_rsp = 0;
    int          rsp_delay = 0;
    logic [31:0] rsp_data = '0;
    int          stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: pick the addressed lane with a shift, then extend arithmetically.
    function automatic logic [31:0] load_val(input int op, input int off, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] b;
        logic [31:0] h;
        sh = rdata >> (8 * off);
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (op)
            1:       return (b >= 128) ? b - 32'd256 : b;
            2:       return (h >= 32768) ? h - 32'd65536 : h;
            4:       return b;
            5:       return h;
            default: return rdata;
        endcase
    endfunction

    task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                         input bit rdwe, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] rdata, input bit expect_wb);
        int   o;
        int   off;
        int   size;
        int   n;
        req_t r;
        wb_t  w;
        o    = (op > 8) ? 0 : op;
        off  = int'(addr % 4);
        size = (o == 2 || o == 5 || o == 7) ? 2 : ((o == 3 || o == 8) ? 4 : 1);
        if (o == 0) begin
            if (rdwe && rd != 0 && expect_wb) begin
                w.waddr = rd; w.wdata = alu; exp_wb.push_back(w);
            end
        end else if (off % size != 0) begin
            exp_mis++;
        end else begin
            r.addr  = addr - 32'(off);
            r.we    = (o >= 6);
            r.rdata = rdata;
            r.wdata = '0;
            r.wstrb = '0;
            if (o == 6) begin r.wdata = (sdata & 32'hFF) * 32'h01010101;   r.wstrb = 4'(1 << off); end
            if (o == 7) begin r.wdata = (sdata & 32'hFFFF) * 32'h00010001; r.wstrb = 4'(3 << off); end
            if (o == 8) begin r.wdata = sdata;                             r.wstrb = 4'hF;         end
            exp_req.push_back(r);
            if (!r.we && rdwe && rd != 0 && expect_wb) begin
                w.waddr = rd; w.wdata = load_val(o, off, rdata); exp_wb.push_back(w);
            end
        end
        n = 0;
        @(negedge clk);
        while (!ex_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ex_ready_timeout", {31'b0, ex_ready}, 32'd1);
        ex_valid      = 1'b1;
        ex_mem_op     = 4'(op);
        ex_addr       = addr;
        ex_store_data = sdata;
        ex_rd_we      = rdwe;
        ex_rd_waddr   = rd;
        ex_alu_result = alu;
        @(posedge clk);
        #1;
        ex_valid      = 1'b0;
        ex_mem_op     = 4'($urandom);
        ex_addr       = $urandom;
    endtask

    // Memory model: checks each presented request, stalls randomly, returns load data later.
    initial begin
        req_t r;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = $urandom;
            if (rst) begin
                mem_req_ready = 1'b0;
            end else begin
                if (rsp_pending) begin
                    if (!hold_rsp) begin
                        if (rsp_delay == 0) begin
                            mem_rsp_valid = 1'b1;
                            mem_rsp_rdata = rsp_data;
                            rsp_pending   = 0;
                        end else begin
                            rsp_delay--;
                        end
                    end
                end else begin
                    mem_rsp_valid = ($urandom % 4 == 0);
                end
                if (mem_req_valid) begin
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected", {31'b0, mem_req_valid}, 32'd0);
                        mem_req_ready = 1'b1;
                    end else begin
                        r = exp_req[0];
                        chk("req_addr", mem_req_addr, r.addr);
                        chk("req_we", {31'b0, mem_req_we}, {31'b0, r.we});
                        chk("req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, r.wstrb});
                        if (r.we) chk("req_wdata", mem_req_wdata, r.wdata);
                        if (stall_cnt > 0) begin
                            mem_req_ready = 1'b0;
                            stall_cnt--;
                        end else begin
                            mem_req_ready = ($urandom % 2 == 0);
                        end
                        if (mem_req_ready) begin
                            void'(exp_req.pop_front());
                            if (!r.we) begin
                                rsp_pending = 1;
                                rsp_delay   = $urandom % 4;
                                rsp_data    = r.rdata;
                            end
                        end
                    end
                end else begin
                    mem_req_ready = ($urandom % 2 == 0);
                end
            end
        end
    end

    // Writeback and misalign monitors.
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (!rst && wb_rd_we) begin
                if (exp_wb.size() == 0) begin
                    chk("wb_unexpected", {31'b0, wb_rd_we}, 32'd0);
                end else begin
                    w = exp_wb.pop_front();
                    chk("wb_waddr", {27'b0, wb_rd_waddr}, {27'b0, w.waddr});
                    chk("wb_wdata", wb_rd_wdata, w.wdata);
                end
            end
            if (!rst && misalign) begin
                chk("misalign_expected", {31'b0, (exp_mis > 0)}, 32'd1);
                if (exp_mis > 0) exp_mis--;
            end
        end
    end

    initial begin
        int n;
        rst           = 1'b1;
        ex_valid      = 1'b0;
        ex_mem_op     = '0;
        ex_addr       = '0;
        ex_store_data = '0;
        ex_rd_we      = 1'b0;
        ex_rd_waddr   = '0;
        ex_alu_result = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_req_we", {31'b0, mem_req_we}, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        chk("rst_req_wdata", mem_req_wdata, 32'd0);
        chk("rst_req_wstrb", {28'b0, mem_req_wstrb}, 32'd0);
        chk("rst_wb_we", {31'b0, wb_rd_we}, 32'd0);
        chk("rst_wb_waddr", {27'b0, wb_rd_waddr}, 32'd0);
        chk("rst_wb_wdata", wb_rd_wdata, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);

        issue(0, 32'h0, 32'h0, 1, 5'd5, 32'h1234, 32'h0, 1);
        issue(1, 32'h8000_0003, 32'h0, 1, 5'd7, 32'h0, 32'h80FF_0000, 1);
        issue(5, 32'h8000_0002, 32'h0, 1, 5'd8, 32'h0, 32'hBEEF_1234, 1);
        issue(2, 32'h8000_0002, 32'h0, 1, 5'd9, 32'h0, 32'hBEEF_1234, 1);
        stall_cnt = 3;
        issue(7, 32'h8000_0006, 32'h0000_ABCD, 1, 5'd3, 32'h0, 32'h0, 1);
        issue(3, 32'h8000_0001, 32'h0, 1, 5'd4, 32'h0, 32'h0, 1);
        @(negedge clk);
        chk("misalign_ex_ready", {31'b0, ex_ready}, 32'd1);
        issue(0, 32'h0, 32'h0, 1, 5'd0, 32'hDEAD_BEEF, 32'h0, 1);

        // Abort an outstanding load with reset; the late response must vanish.
        hold_rsp = 1;
        issue(3, 32'h8000_0010, 32'h0, 1, 5'd6, 32'h0, 32'h1111_2222, 0);
        n = 0;
        while (!rsp_pending && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_wait_timeout", {31'b0, rsp_pending}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_ex_ready", {31'b0, ex_ready}, 32'd1);
        chk("abort_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("abort_wb_we", {31'b0, wb_rd_we}, 32'd0);
        hold_rsp = 0;
        repeat (8) @(negedge clk);
        chk("abort_idle_ready", {31'b0, ex_ready}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            issue(int'($urandom % 16), 32'h8000_0000 + ($urandom % 256), $urandom,
                  1'($urandom), 5'($urandom), $urandom, $urandom, 1);
        end

        n = 0;
        while ((exp_req.size() != 0 || exp_wb.size() != 0 || exp_mis != 0 || rsp_pending) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_req", exp_req.size(), 32'd0);
        chk("drain_wb", exp_wb.size(), 32'd0);
        chk("drain_misalign", exp_mis, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
